// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver
package uart_pkg;
  typedef enum logic [1:0] {NONE, EVEN, ODD} parity_mode_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync_vote.sv
// uart_rx_sync_vote: input synchroniser, falling-edge detect and 3-sample majority vote
module uart_rx_sync_vote #(
  parameter int SYNC_STAGES = 2,
  parameter int CW = 12,
  parameter int MID = 1600
) (
  input logic clk,
  input logic rst,
  input logic rx_in,
  input logic [CW-1:0] cnt,
  output logic rxs,
  output logic fall_edge,
  output logic vote
);
  logic [SYNC_STAGES-1:0] sync, fill;
  logic prev;
  logic [1:0] smp;
  // history only trusts rxs once the idle-high reset values have flushed, so a line stuck low never starts a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      fill <= '0;
      prev <= 1'b0;
      smp <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_in};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev <= rxs & fill[SYNC_STAGES-1];
      if (cnt == CW'(MID - 1)) smp[0] <= rxs;
      if (cnt == CW'(MID)) smp[1] <= rxs;
    end
  end
  assign rxs = sync[SYNC_STAGES-1];
  assign fall_edge = prev & ~rxs;
  assign vote = (smp[0] & smp[1]) | (rxs & (smp[0] | smp[1]));
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority voting, parity/framing checks and ready/valid output
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD = 31_250,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_100mhz,
  input logic reset,
  input logic rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic data_valid,
  input logic data_ready,
  output logic parity_err,
  output logic framing_err,
  output logic overrun,
  output logic busy
);
  localparam int CPB = cycles_per_bit(CLK_HZ, BAUD);
  localparam int MID = CPB / 2;
  localparam int CW = $clog2(CPB);
  localparam parity_mode_t PM = parity_mode_t'(PARITY_MODE[1:0]);
  if (CPB < 8 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || SYNC_STAGES < 2) begin : g_bad_cfg
    $fatal(1, "uart_rx_param: unsupported configuration");
  end
  rx_state_t state, next;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] shreg;
  logic pbit, ferr, unused_rxs, fall_edge, vote, end_bit, dec, last, commit, perr;
  uart_rx_sync_vote #(.SYNC_STAGES(SYNC_STAGES), .CW(CW), .MID(MID)) u_sync (
    .clk(clk_100mhz),
    .rst(reset),
    .rx_in(rx_in),
    .cnt(cnt),
    .rxs(unused_rxs),
    .fall_edge(fall_edge),
    .vote(vote)
  );
  assign end_bit = cnt == CW'(CPB - 1);
  assign dec = cnt == CW'(MID + 1);
  assign last = dec && idx == 4'(STOP_BITS - 1);
  assign commit = state == STOP && last;
  assign perr = PM != NONE && ((^shreg ^ pbit) != (PM == ODD));
  assign busy = state != IDLE;
  // bits advance on their last cycle; false starts and the final stop decision return early at the vote
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = fall_edge ? START : IDLE;
      START: next = (dec && vote) ? IDLE : end_bit ? DATA : START;
      DATA: next = !(end_bit && idx == 4'(DATA_BITS - 1)) ? DATA : (PM == NONE) ? STOP : PARITY;
      PARITY: next = end_bit ? STOP : PARITY;
      STOP: next = last ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  // the IDLE detect cycle is count 0 of the start bit; a frame is dropped when the previous word is still unread
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      pbit <= 1'b0;
      ferr <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= next;
      cnt <= (next == IDLE || end_bit) ? '0 : cnt + 1'b1;
      idx <= (next != state) ? '0 : end_bit ? idx + 1'b1 : idx;
      if (state == DATA && dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state == PARITY && dec) pbit <= vote;
      if (state == START) ferr <= 1'b0;
      else if (state == STOP && dec && !vote) ferr <= 1'b1;
      if (commit && (!data_valid || data_ready)) begin
        data_out <= shreg;
        parity_err <= perr;
        framing_err <= ferr | ~vote;
        data_valid <= 1'b1;
      end else begin
        if (commit) overrun <= 1'b1;
        if (data_ready) data_valid <= 1'b0;
      end
    end
  end
endmodule
